// File: rtl/debounce_arbiter.sv
// debounce_arbiter: N_CH push-button debouncers sharing one delay timer.
// Each channel runs a small IDLE/PEND/DELAY/HELD FSM. A round-robin arbiter
// hands the single timer to one pending channel at a time.
// Optional feature macro: DEBOUNCE_SYNC_EN adds a 2-flop synchroniser per input.
module debounce_arbiter #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned DELAY_CYCLES = 50000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_CH-1:0]         signal_i,
  output logic [N_CH-1:0]         press_o,
  output logic [N_CH-1:0]         level_o,
  output logic                    busy_o,
  output logic [$clog2(N_CH)-1:0] grant_idx_o
);

  localparam int unsigned IDX_W = $clog2(N_CH);
  localparam int unsigned CNT_W = $clog2(DELAY_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_DELAY = 2'd2,
    ST_HELD  = 2'd3
  } state_t;

  logic [N_CH-1:0]  w_s;

  state_t           r_state     [N_CH];
  state_t           w_state_nxt [N_CH];

  logic [N_CH-1:0]  r_press;
  logic [N_CH-1:0]  w_press_nxt;
  logic [N_CH-1:0]  r_level;
  logic [N_CH-1:0]  w_level_nxt;

  logic             r_busy;
  logic             w_busy_nxt;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_nxt;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] w_owner_nxt;
  logic [IDX_W-1:0] r_rr;
  logic [IDX_W-1:0] w_rr_nxt;

  logic             w_grant_vld;
  logic [IDX_W-1:0] w_grant_idx;
  logic [IDX_W-1:0] w_cand;

`ifdef DEBOUNCE_SYNC_EN
  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;

  // Two-flop synchroniser bringing raw button pins into the clk_i domain.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= signal_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = signal_i;
`endif

  // Round-robin pick: first channel at/after the pointer that is pending and
  // still requesting; a channel dropping its input this cycle is skipped.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    if (!r_busy) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        w_cand = IDX_W'((32'(r_rr) + i) % N_CH);
        if (!w_grant_vld && (r_state[w_cand] == ST_PEND) && w_s[w_cand]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = w_cand;
        end
      end
    end
  end

  // Per-channel next state plus the registered press pulse and held level.
  always_comb begin
    w_press_nxt = '0;
    w_level_nxt = '0;
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      w_state_nxt[ch] = r_state[ch];
      case (r_state[ch])
        ST_IDLE: begin
          if (w_s[ch]) w_state_nxt[ch] = ST_PEND;
        end
        ST_PEND: begin
          if (!w_s[ch]) begin
            w_state_nxt[ch] = ST_IDLE;
          end else if (w_grant_vld && (w_grant_idx == IDX_W'(ch))) begin
            w_state_nxt[ch] = ST_DELAY;
          end
        end
        ST_DELAY: begin
          // Only the timer owner can be here, so the shared timer is its own.
          if (r_timer == '0) begin
            if (w_s[ch]) begin
              w_state_nxt[ch] = ST_HELD;
              w_press_nxt[ch] = 1'b1;
            end else begin
              w_state_nxt[ch] = ST_IDLE;
            end
          end
        end
        ST_HELD: begin
          if (!w_s[ch]) w_state_nxt[ch] = ST_IDLE;
        end
        default: w_state_nxt[ch] = ST_IDLE;
      endcase
      w_level_nxt[ch] = (w_state_nxt[ch] == ST_HELD);
    end
  end

  // Shared timer ownership: load on grant, count down, free when it hits zero.
  always_comb begin
    w_busy_nxt  = r_busy;
    w_timer_nxt = r_timer;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr;
    if (r_busy) begin
      if (r_timer == '0) begin
        w_busy_nxt = 1'b0;
      end else begin
        w_timer_nxt = r_timer - CNT_W'(1);
      end
    end else if (w_grant_vld) begin
      w_busy_nxt  = 1'b1;
      w_timer_nxt = CNT_W'(DELAY_CYCLES - 1);
      w_owner_nxt = w_grant_idx;
      w_rr_nxt    = IDX_W'((32'(w_grant_idx) + 1) % N_CH);
    end
  end

  // Channel FSM state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        r_state[ch] <= ST_IDLE;
      end
    end else begin
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        r_state[ch] <= w_state_nxt[ch];
      end
    end
  end

  // Timer, arbiter and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_busy  <= 1'b0;
      r_timer <= '0;
      r_owner <= '0;
      r_rr    <= '0;
      r_press <= '0;
      r_level <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_timer <= w_timer_nxt;
      r_owner <= w_owner_nxt;
      r_rr    <= w_rr_nxt;
      r_press <= w_press_nxt;
      r_level <= w_level_nxt;
    end
  end

  assign press_o     = r_press;
  assign level_o     = r_level;
  assign busy_o      = r_busy;
  assign grant_idx_o = r_owner;

endmodule
